// File: rtl/ir_frame_assembler_if.sv
// ---------------------------------------------------------------------------
// ir_frame_assembler_if
//
// Groups the symbol input, the byte-stream output handshake and the frame
// status outputs of ir_frame_assembler. clk/reset stay plain module ports.
//
// Handshake: on the output stream a byte is transferred on every rising edge
// where out_valid=1 and out_ready=1; while out_valid=1 and out_ready=0 the
// producer holds out_data/out_last stable, and out_valid never depends on
// out_ready. On the input side sym_valid is a one-cycle strobe with no
// back-pressure: every symbol presented with sym_valid=1 is consumed.
//
// Signals
//   sym_valid  : strobe qualifying sym_code
//   sym_code   : 00 STOP, 01 START, 10 ZERO, 11 ONE
//   out_data   : FIFO head byte (0 when empty)
//   out_last   : head byte closes its frame
//   out_valid  : FIFO non-empty
//   out_ready  : consumer accepts head byte
//   frame_done : one-cycle pulse when a frame closes
//   frame_ok   : verdict for the frame reported with frame_done
//   frame_len  : byte count of last closed frame (saturates at 63)
//   overflow   : sticky, a byte was dropped because the FIFO was full
//   dbg_state  : current FSM state (0 IDLE, 1 COLLECT)
// ---------------------------------------------------------------------------
interface ir_frame_assembler_if;
  logic       sym_valid;
  logic [1:0] sym_code;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;
  logic       frame_ok;
  logic [5:0] frame_len;
  logic       overflow;
  logic       dbg_state;

  // Symbol source and byte consumer side.
  modport master (
    output sym_valid, sym_code, out_ready,
    input  out_data, out_last, out_valid, frame_done, frame_ok, frame_len,
           overflow, dbg_state
  );

  // Frame assembler side.
  modport slave (
    input  sym_valid, sym_code, out_ready,
    output out_data, out_last, out_valid, frame_done, frame_ok, frame_len,
           overflow, dbg_state
  );
endinterface

// File: rtl/ir_frame_assembler.sv
// ---------------------------------------------------------------------------
// ir_frame_assembler
//
// Turns a stream of decoded pulse-distance IR symbols into bytes, groups the
// bytes into frames (START ... STOP) and queues them in a FIFO of 9-bit
// entries {last, data}. The last byte of each frame is a checksum: a frame
// is good when it has at least two bytes, no partial byte at the close, no
// byte dropped on a full FIFO, and the mod-256 sum of all earlier bytes
// equals the final byte.
//
// Ports
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : ir_frame_assembler_if.slave (symbols in, bytes/status out)
//
// Parameter
//   DEPTH : FIFO entries, power of two, 4..64
// ---------------------------------------------------------------------------
module ir_frame_assembler #(
  parameter int DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  ir_frame_assembler_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t      state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt_q;
  logic [5:0]  byte_cnt_q;
  logic [7:0]  sum_q;
  logic [7:0]  staged_q;
  logic        err_q;

  logic        frame_done_q;
  logic        frame_ok_q;
  logic [5:0]  frame_len_q;
  logic        overflow_q;

  logic [8:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  // -------------------------------------------------------------------------
  // Symbol decode
  // -------------------------------------------------------------------------
  logic       in_collect;
  logic       sym_start;
  logic       sym_stop;
  logic       sym_bit;
  logic       close_frame;
  logic       byte_done;
  logic       has_staged;
  logic [7:0] new_byte;

  assign in_collect  = (state_q == S_COLLECT);
  assign sym_start   = bus.sym_valid && (bus.sym_code == 2'b01);
  assign sym_stop    = bus.sym_valid && (bus.sym_code == 2'b00);
  assign sym_bit     = bus.sym_valid && bus.sym_code[1];
  assign close_frame = in_collect && (sym_start || sym_stop);
  assign byte_done   = in_collect && sym_bit && (bit_cnt_q == 3'd7);
  assign has_staged  = (byte_cnt_q != 6'd0);
  // LSB-first: the newest bit enters at bit 7 and older bits move right.
  assign new_byte    = {bus.sym_code[0], shift_q[7:1]};

  // -------------------------------------------------------------------------
  // FIFO push/pop decisions
  // -------------------------------------------------------------------------
  // The staged byte is held back one byte so that, at the close, it can be
  // pushed with last=1 and compared against the running sum.
  logic       push_req;
  logic [8:0] push_entry;
  logic       fifo_full;
  logic       fifo_pop;
  logic       push_ok;
  logic       push_drop;

  assign push_req   = (byte_done || close_frame) && has_staged;
  assign push_entry = {close_frame, staged_q};
  // Full uses the occupancy before this edge, so a simultaneous pop does
  // not rescue a push into a full FIFO.
  assign fifo_full  = (count_q == DEPTH_CNT);
  assign fifo_pop   = (count_q != '0) && bus.out_ready;
  assign push_ok    = push_req && !fifo_full;
  assign push_drop  = push_req && fifo_full;

  // Verdict for the frame being closed this cycle; a drop of the closing
  // byte itself also spoils the frame.
  logic close_ok;
  assign close_ok = (byte_cnt_q >= 6'd2) && !err_q && (bit_cnt_q == 3'd0) &&
                    !push_drop && (sum_q == staged_q);

  // -------------------------------------------------------------------------
  // Frame FSM and status outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      sum_q        <= '0;
      staged_q     <= '0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_len_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (push_drop) begin
        overflow_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (sym_start) begin
            state_q    <= S_COLLECT;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            sum_q      <= '0;
            staged_q   <= '0;
            err_q      <= 1'b0;
          end
        end

        S_COLLECT: begin
          if (close_frame) begin
            frame_done_q <= 1'b1;
            frame_ok_q   <= close_ok;
            frame_len_q  <= byte_cnt_q;
            // START closes and immediately reopens; STOP returns to IDLE.
            state_q      <= sym_start ? S_COLLECT : S_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            sum_q        <= '0;
            staged_q     <= '0;
            err_q        <= 1'b0;
          end else if (sym_bit) begin
            shift_q <= new_byte;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              staged_q  <= new_byte;
              // The sum excludes the staged byte: the outgoing staged byte
              // joins it only now that a newer byte replaces it.
              if (has_staged) begin
                sum_q <= sum_q + staged_q;
              end
              if (byte_cnt_q != 6'd63) begin
                byte_cnt_q <= byte_cnt_q + 6'd1;
              end
              if (push_drop) begin
                err_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, fifo_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only ever read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic [8:0] head;
  assign head = mem_q[rd_ptr_q];

  // Outputs are forced to zero when empty so reset and idle present 0.
  assign bus.out_valid  = (count_q != '0);
  assign bus.out_data   = bus.out_valid ? head[7:0] : 8'd0;
  assign bus.out_last   = bus.out_valid ? head[8]   : 1'b0;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_ok   = frame_ok_q;
  assign bus.frame_len  = frame_len_q;
  assign bus.overflow   = overflow_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_ir_frame_assembler.sv
// ---------------------------------------------------------------------------
// tb_ir_frame_assembler
//
// Drives symbol sequences (directed and random) into ir_frame_assembler.
// A reference model tracks frames as lists of bits/bytes and the FIFO as a
// plain occupancy count; expected FIFO entries go to exp_q, expected frame
// verdicts to frm_q. A negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_ir_frame_assembler;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ir_frame_assembler_if bus ();

  ir_frame_assembler #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  bit monitor_on = 1'b0;

  logic [8:0] exp_q[$];
  typedef struct packed {
    logic       ok;
    logic [5:0] len;
  } frame_t;
  frame_t frm_q[$];

  // ---------------- reference model ----------------
  bit     m_collect;
  int     m_bits[$];
  int     m_bytes[$];
  bit     m_dropped;
  int     m_occ;
  bit     m_ovf;

  int rdy_pct = 100;
  int gap_max = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_collect = 0; m_bits.delete(); m_bytes.delete(); m_dropped = 0;
    m_occ = 0; m_ovf = 0; exp_q.delete(); frm_q.delete();
  endtask

  task automatic model_start();
    m_collect = 1; m_bits.delete(); m_bytes.delete(); m_dropped = 0;
  endtask

  // Uses the occupancy before the edge; any pop is applied afterwards.
  task automatic model_push(input logic [8:0] e);
    if (m_occ == DEPTH) begin
      m_dropped = 1;
      m_ovf = 1;
    end else begin
      exp_q.push_back(e);
      m_occ++;
    end
  endtask

  task automatic model_close();
    int n;
    int sum;
    frame_t fr;
    n = m_bytes.size();
    if (n > 0) model_push({1'b1, 8'(m_bytes[n-1])});
    sum = 0;
    for (int i = 0; i < n - 1; i++) sum += m_bytes[i];
    fr.ok  = (n >= 2) && (m_bits.size() == 0) && !m_dropped &&
             (n > 0 && (sum % 256) == m_bytes[n-1]);
    fr.len = (n > 63) ? 6'd63 : 6'(n);
    frm_q.push_back(fr);
  endtask

  task automatic model_edge(input bit v, input logic [1:0] c, input bit rdy);
    bit pop;
    int b;
    pop = (m_occ > 0) && rdy;
    if (v) begin
      if (!m_collect) begin
        if (c == 2'b01) model_start();
      end else if (c[1]) begin
        m_bits.push_back(int'(c[0]));
        if (m_bits.size() == 8) begin
          b = 0;
          foreach (m_bits[i]) b |= m_bits[i] << i;
          m_bits.delete();
          if (m_bytes.size() > 0) model_push({1'b0, 8'(m_bytes[m_bytes.size()-1])});
          m_bytes.push_back(b);
        end
      end else begin
        model_close();
        if (c == 2'b01) model_start();
        else m_collect = 0;
      end
    end
    if (pop) m_occ--;
  endtask

  // ---------------- driver tasks ----------------
  function automatic bit pick_rdy();
    return $urandom_range(99) < rdy_pct;
  endfunction

  task automatic cyc(input bit v, input logic [1:0] c, input bit rdy);
    bus.sym_valid = v;
    bus.sym_code  = c;
    bus.out_ready = rdy;
    @(posedge clk);
    model_edge(v, c, rdy);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 2'($urandom), pick_rdy());
  endtask

  task automatic sym(input logic [1:0] c);
    idle($urandom_range(gap_max));
    cyc(1'b1, c, pick_rdy());
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) sym(b[i] ? 2'b11 : 2'b10);
  endtask

  task automatic drain();
    rdy_pct = 100;
    idle(DEPTH + 4);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (monitor_on) begin
      if (bus.frame_done) begin
        if (frm_q.size() == 0) begin
          check("unexpected_frame_done", 1, 0);
        end else begin
          frame_t fr;
          fr = frm_q.pop_front();
          check("frame_ok", bus.frame_ok, fr.ok);
          check("frame_len", bus.frame_len, fr.len);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_pops++;
        if (exp_q.size() == 0) check("unexpected_byte", {bus.out_last, bus.out_data}, 9'h1ff);
        else check("fifo_entry", {bus.out_last, bus.out_data}, exp_q.pop_front());
      end
      check("out_valid", bus.out_valid, m_occ > 0);
      check("overflow", bus.overflow, m_ovf);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"},  bus.out_valid, 0);
    check({tag, "_out_data"},   bus.out_data, 0);
    check({tag, "_out_last"},   bus.out_last, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_frame_ok"},   bus.frame_ok, 0);
    check({tag, "_frame_len"},  bus.frame_len, 0);
    check({tag, "_overflow"},   bus.overflow, 0);
  endtask

  initial begin
    bit open;
    int pops0;
    logic [7:0] b;
    logic [7:0] s;
    int nb;

    bus.sym_valid = 1'b0;
    bus.sym_code  = 2'b00;
    bus.out_ready = 1'b0;
    model_reset();

    // Reset state
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    monitor_on = 1'b1;

    // Symbols before any START are ignored
    rdy_pct = 100; gap_max = 0;
    sym(2'b10); sym(2'b11); sym(2'b00); idle(3);

    // Good frame 11 22 33
    sym(2'b01); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); sym(2'b00);
    idle(DEPTH + 2);

    // Bad checksum 11 22 34
    sym(2'b01); send_byte(8'h11); send_byte(8'h22); send_byte(8'h34); sym(2'b00);
    idle(DEPTH + 2);

    // One byte plus 5 partial bits
    sym(2'b01); send_byte(8'hAA);
    repeat (5) sym($urandom_range(1) ? 2'b11 : 2'b10);
    sym(2'b00);
    idle(DEPTH + 2);

    // Back-to-back frames closed by START
    sym(2'b01); send_byte(8'h05); send_byte(8'h05);
    sym(2'b01); send_byte(8'h01); send_byte(8'h01); sym(2'b00);
    idle(DEPTH + 2);

    // Random frames
    open = 0;
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(2))
        0: rdy_pct = 30;
        1: rdy_pct = 70;
        default: rdy_pct = 100;
      endcase
      gap_max = $urandom_range(2);
      if (!open) sym(2'b01);
      nb = $urandom_range(6);
      s = 8'd0;
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        if (i == nb - 1 && $urandom_range(1) == 1) b = s;
        send_byte(b);
        s = s + b;
      end
      if ($urandom_range(4) == 0) repeat ($urandom_range(1, 7)) sym($urandom_range(1) ? 2'b11 : 2'b10);
      if ($urandom_range(2) == 0) begin
        sym(2'b01); open = 1;
      end else begin
        sym(2'b00); open = 0;
      end
    end
    if (open) sym(2'b00);
    gap_max = 0;
    drain();

    // Overflow: 7 bytes into a 4-deep FIFO with the consumer stalled
    rdy_pct = 0;
    sym(2'b01);
    for (int i = 0; i < 7; i++) send_byte(8'(8'h40 + i));
    sym(2'b00);
    idle(3);
    check("ovf_sticky", bus.overflow, 1);
    check("ovf_held_head", {bus.out_last, bus.out_data}, 9'h040);
    pops0 = n_pops;
    drain();
    check("ovf_drain_count", n_pops - pops0, 4);

    // Reset mid-frame with data held in the FIFO
    rdy_pct = 0;
    sym(2'b01); send_byte(8'h5A); send_byte(8'h3C); sym(2'b11); sym(2'b10);
    monitor_on = 1'b0;
    bus.sym_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_all_zero("midreset");
    @(posedge clk); #1;
    model_reset();
    reset = 1'b0;
    monitor_on = 1'b1;

    // First symbol after reset handled from IDLE
    rdy_pct = 100;
    sym(2'b11);
    sym(2'b01); send_byte(8'h21); send_byte(8'h21); sym(2'b00);
    drain();

    check("exp_q_empty", exp_q.size(), 0);
    check("frm_q_empty", frm_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_frame_assembler.md
IR_FRAME_ASSEMBLER -- requirements
Module: ir_frame_assembler

Interface
REQ-001 SHALL have parameter DEPTH, default 32, FIFO entries (power of two, 4..64).
REQ-002 SHALL have port clk  input  1  system clock, 12 MHz, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sym_valid  input  1  one-cycle strobe qualifying sym_code.
REQ-005 SHALL have port sym_code  input  2  pulse-distance symbol: 00 STOP, 01 START, 10 ZERO, 11 ONE.
REQ-006 SHALL have port out_data  output  8  FIFO head byte.
REQ-007 SHALL have port out_last  output  1  head byte is final byte of its frame.
REQ-008 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port out_ready  input  1  consumer accepts head when out_valid & out_ready.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse on frame close.
REQ-011 SHALL have port frame_ok  output  1  checksum/length verdict, meaningful only with frame_done.
REQ-012 SHALL have port frame_len  output  6  byte count of closed frame, saturating at 63, held until next frame_done.
REQ-013 SHALL have port overflow  output  1  sticky: a byte was dropped on FIFO full.

Function
REQ-014 SHALL implement FSM states IDLE and COLLECT; symbols are sampled only when sym_valid=1.
REQ-015 IDLE: START -> COLLECT, clearing bit count, byte count, running sum, staging register and frame error flag; ZERO/ONE/STOP ignored.
REQ-016 COLLECT: ZERO/ONE shift bit into an 8-bit shift register LSB-first (new bit enters bit 7, shift right).
REQ-017 On 8th bit: completed byte loads staging register; previously staged byte (if any) is pushed to FIFO with last=0 on the same edge.
REQ-018 Running sum SHALL be mod-256 sum of all completed bytes except the currently staged one.
REQ-019 STOP in COLLECT SHALL close the frame: staged byte pushed with last=1, FSM -> IDLE.
REQ-020 START in COLLECT SHALL close the current frame exactly as STOP, then begin a new frame (state stays COLLECT, counters cleared).
REQ-021 Close with bit count != 0: partial bits discarded, frame error set.
REQ-022 frame_ok SHALL be 1 iff byte count >= 2, no frame error, no byte dropped in this frame, and running sum == staged byte.
REQ-023 Close with zero bytes: nothing pushed, frame_done pulses, frame_ok=0, frame_len=0.
REQ-024 frame_done, frame_ok, frame_len SHALL update on the edge after the closing symbol is sampled (latency 1).
REQ-025 FIFO entries SHALL be 9 bits {last, data}; pushed entry visible on out_* no earlier than the cycle after the push edge.
REQ-026 Pop on edge where out_valid & out_ready; out_data/out_last SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 Full is evaluated from pre-edge occupancy: push while full is dropped even if a pop occurs on the same edge; drop sets overflow and frame error.
REQ-028 Push and pop on the same edge when not full SHALL both take effect; occupancy unchanged.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter width log2(DEPTH)+1.
REQ-030 overflow SHALL clear only on reset.

Reset
REQ-031 reset=1 SHALL asynchronously force: IDLE, FIFO empty, out_valid=0, out_data=0, out_last=0, frame_done=0, frame_ok=0, frame_len=0, overflow=0, all counters/sum/staging cleared.
REQ-032 Reset mid-frame SHALL discard the frame with no frame_done; first symbol after release handled from IDLE.

Verification
REQ-033 START, bytes 0x11,0x22,0x33 LSB-first, STOP, out_ready=1 -> FIFO emits 0x11/0,0x22/0,0x33/1; frame_done one cycle after STOP, frame_ok=1, frame_len=3.
REQ-034 START, 0x11,0x22,0x34, STOP -> same bytes emitted, frame_ok=0, frame_len=3.
REQ-035 START, 0xAA, 5 bits, STOP -> only 0xAA/last=1 pushed; frame_ok=0, frame_len=1.
REQ-036 DEPTH=4, out_ready=0, START, 7 bytes, STOP -> 4 entries held, overflow=1, frame_ok=0; releasing out_ready drains exactly 4 entries in order.
REQ-037 START, 0x05,0x05, START, 0x01,0x01, STOP -> two frame_done pulses, both frame_ok=1, out_last=1 on 2nd and 4th bytes.
REQ-038 ZERO/ONE/STOP before any START -> no push, no frame_done; assert reset mid-frame -> all outputs 0 immediately.
